// File: rtl/regfile_write_packer.sv
// Packs pairs of WIDTH-bit products into 2*WIDTH-bit register-file words.
// Writes go to consecutive addresses until the file is full.
module regfile_write_packer #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    flush,
    input  logic                    clear,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [2*WIDTH-1:0]      wr_data,
    output logic [ADDR_WIDTH:0]     count,
    output logic                    full
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [WIDTH-1:0]        lo_r;
    logic [WIDTH-1:0]        lo_nx_s;
    logic [ADDR_WIDTH-1:0]   ptr_r;
    logic [ADDR_WIDTH:0]     count_r;
    logic                    full_r;
    logic                    wr_en_r;
    logic [ADDR_WIDTH-1:0]   wr_addr_r;
    logic [2*WIDTH-1:0]      wr_data_r;
    logic                    accept_s;
    logic                    issue_s;
    logic [2*WIDTH-1:0]      word_s;

    // Readiness depends only on registered state so it never loops back through in_valid.
    assign in_ready = rst_n && !full_r;
    assign accept_s = in_valid && in_ready;

    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign count   = count_r;
    assign full    = full_r;

    // Next state, low-half capture and write-issue decision.
    always_comb begin
        state_nx_s = state_r;
        lo_nx_s    = lo_r;
        issue_s    = 1'b0;
        word_s     = wr_data_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s && flush) begin
                    issue_s = 1'b1;
                    word_s  = {{WIDTH{1'b0}}, in_data};
                end else if (accept_s) begin
                    state_nx_s = ST_HALF;
                    lo_nx_s    = in_data;
                end else begin
                    state_nx_s = ST_EMPTY;
                end
            end
            ST_HALF: begin
                // A completing product takes precedence over a concurrent flush.
                if (accept_s) begin
                    issue_s    = 1'b1;
                    word_s     = {in_data, lo_r};
                    state_nx_s = ST_EMPTY;
                end else if (flush) begin
                    issue_s    = 1'b1;
                    word_s     = {{WIDTH{1'b0}}, lo_r};
                    state_nx_s = ST_EMPTY;
                end else begin
                    state_nx_s = ST_HALF;
                end
            end
            default: begin
                state_nx_s = ST_EMPTY;
            end
        endcase
    end

    // State, pointer, fill level and write-port registers; clear overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_EMPTY;
            lo_r      <= {WIDTH{1'b0}};
            ptr_r     <= {ADDR_WIDTH{1'b0}};
            count_r   <= {(ADDR_WIDTH+1){1'b0}};
            full_r    <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_WIDTH{1'b0}};
            wr_data_r <= {(2*WIDTH){1'b0}};
        end else if (clear) begin
            state_r <= ST_EMPTY;
            lo_r    <= {WIDTH{1'b0}};
            ptr_r   <= {ADDR_WIDTH{1'b0}};
            count_r <= {(ADDR_WIDTH+1){1'b0}};
            full_r  <= 1'b0;
            wr_en_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            lo_r    <= lo_nx_s;
            wr_en_r <= issue_s;
            if (issue_s) begin
                wr_addr_r <= ptr_r;
                wr_data_r <= word_s;
                ptr_r     <= (ptr_r == PTR_LAST) ? {ADDR_WIDTH{1'b0}} : ptr_r + PTR_ONE;
                count_r   <= count_r + CNT_ONE;
                full_r    <= ((count_r + CNT_ONE) == DEPTH_C);
            end else begin
                ptr_r   <= ptr_r;
                count_r <= count_r;
                full_r  <= full_r;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_packer.sv
// Scoreboard bench for regfile_write_packer: expected writes are queued when the
// completing product is driven and popped by a monitor when wr_en appears.
module tb_regfile_write_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        flush;
    logic        clear;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [4:0]  count;
    logic        full;

    int tests_run = 0;
    int fails     = 0;
    logic [19:0] exp_q [$];

    regfile_write_packer #(.WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .clear(clear), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .count(count), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every write pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            logic [19:0] e;
            tests_run++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    fails++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             wr_addr, wr_data, e[19:16], e[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_queue_drained(input string name);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: got %0d pending writes, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0; clear = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        tests_run++;
        if ({in_ready, wr_en, wr_addr, wr_data, count, full} !== 28'd0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b en=%b addr=%h data=%h cnt=%0d full=%b, required all 0",
                     in_ready, wr_en, wr_addr, wr_data, count, full);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_pair();
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        exp_q.push_back({4'd0, 16'h2211});
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({wr_en, wr_addr, wr_data, count} !== {1'b1, 4'd0, 16'h2211, 5'd1}) begin
            fails++;
            $display("FAIL pair: got en=%b addr=%0d data=%h cnt=%0d, required en=1 addr=0 data=2211 cnt=1",
                     wr_en, wr_addr, wr_data, count);
        end
        tick();
        test_queue_drained("pair");
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        flush = 1'b1;
        exp_q.push_back({4'd1, 16'h00A5});
        tick();
        tests_run++;
        if ({wr_en, wr_addr, wr_data, count} !== {1'b1, 4'd1, 16'h00A5, 5'd2}) begin
            fails++;
            $display("FAIL flush_half: got en=%b addr=%0d data=%h cnt=%0d, required en=1 addr=1 data=00a5 cnt=2",
                     wr_en, wr_addr, wr_data, count);
        end
        tick();
        flush = 1'b0;
        tests_run++;
        if ({wr_en, count} !== {1'b0, 5'd2}) begin
            fails++;
            $display("FAIL flush_empty: got en=%b cnt=%0d, required en=0 cnt=2", wr_en, count);
        end
        test_queue_drained("flush");
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests_run++;
        if ({count, full, in_ready} !== {5'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL b2b_preclear: got cnt=%0d full=%b rdy=%b, required 0 0 1", count, full, in_ready);
        end
        for (int i = 0; i < 32; i++) begin
            v = 8'(i);
            in_valid = 1'b1; in_data = v;
            if (in_ready !== 1'b1) begin
                tests_run++; fails++;
                $display("FAIL b2b_ready: product %0d got rdy=%b, required 1", i, in_ready);
            end
            if (i % 2 == 1) exp_q.push_back({4'(i / 2), v, v - 8'd1});
            tick();
        end
        tests_run++;
        if ({wr_en, full, in_ready, count, wr_addr, wr_data} !== {1'b1, 1'b1, 1'b0, 5'd16, 4'd15, 16'h1F1E}) begin
            fails++;
            $display("FAIL b2b_last: got en=%b full=%b rdy=%b cnt=%0d addr=%0d data=%h, required 1 1 0 16 15 1f1e",
                     wr_en, full, in_ready, count, wr_addr, wr_data);
        end
        in_data = 8'h99;
        tick();
        tick();
        tests_run++;
        if ({in_ready, count, full} !== {1'b0, 5'd16, 1'b1}) begin
            fails++;
            $display("FAIL b2b_blocked: got rdy=%b cnt=%0d full=%b, required 0 16 1", in_ready, count, full);
        end
        test_queue_drained("b2b");
    endtask

    task automatic test_clear();
        in_valid = 1'b1; in_data = 8'hCC; clear = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        tests_run++;
        if ({count, full, in_ready, wr_en} !== {5'd0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL clear_full: got cnt=%0d full=%b rdy=%b en=%b, required 0 0 1 0",
                     count, full, in_ready, wr_en);
        end
        in_valid = 1'b1; in_data = 8'h99;
        tick();
        in_data = 8'h98; clear = 1'b1;
        tick();
        clear = 1'b0;
        in_data = 8'h10;
        tick();
        in_data = 8'h20;
        exp_q.push_back({4'd0, 16'h2010});
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({wr_en, wr_addr, wr_data, count} !== {1'b1, 4'd0, 16'h2010, 5'd1}) begin
            fails++;
            $display("FAIL clear_restart: got en=%b addr=%0d data=%h cnt=%0d, required 1 0 2010 1",
                     wr_en, wr_addr, wr_data, count);
        end
        tick();
        test_queue_drained("clear");
    endtask

    task automatic test_flush_combo();
        in_valid = 1'b1; in_data = 8'h33;
        tick();
        in_data = 8'h44; flush = 1'b1;
        exp_q.push_back({4'd1, 16'h4433});
        tick();
        in_valid = 1'b0; flush = 1'b0;
        tests_run++;
        if ({wr_en, wr_data, count} !== {1'b1, 16'h4433, 5'd2}) begin
            fails++;
            $display("FAIL half_accept_flush: got en=%b data=%h cnt=%0d, required 1 4433 2", wr_en, wr_data, count);
        end
        tick();
        in_valid = 1'b1; in_data = 8'h55; flush = 1'b1;
        exp_q.push_back({4'd2, 16'h0055});
        tick();
        in_valid = 1'b0; flush = 1'b0;
        tests_run++;
        if ({wr_en, wr_addr, wr_data, count} !== {1'b1, 4'd2, 16'h0055, 5'd3}) begin
            fails++;
            $display("FAIL empty_accept_flush: got en=%b addr=%0d data=%h cnt=%0d, required 1 2 0055 3",
                     wr_en, wr_addr, wr_data, count);
        end
        tick();
        test_queue_drained("combo");
    endtask

    task automatic test_reset_midpair();
        in_valid = 1'b1; in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, wr_en, wr_addr, wr_data, count, full} !== 28'd0) begin
            fails++;
            $display("FAIL midpair_reset: got rdy=%b en=%b addr=%h data=%h cnt=%0d full=%b, required all 0",
                     in_ready, wr_en, wr_addr, wr_data, count, full);
        end
        tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        in_valid = 1'b1; in_data = 8'h01;
        tick();
        in_data = 8'h02;
        exp_q.push_back({4'd0, 16'h0201});
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({wr_en, wr_addr, wr_data, count} !== {1'b1, 4'd0, 16'h0201, 5'd1}) begin
            fails++;
            $display("FAIL midpair_restart: got en=%b addr=%0d data=%h cnt=%0d, required 1 0 0201 1",
                     wr_en, wr_addr, wr_data, count);
        end
        tick();
        test_queue_drained("midpair");
    endtask

    initial begin
        test_reset();
        test_pair();
        test_flush();
        test_back_to_back();
        test_clear();
        test_flush_combo();
        test_reset_midpair();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
